ball_mover: RTL
===============

BALL_MOVER -- requirements
Module: ball_mover

Interface
REQ-001 Parameter FIELD_W, default 640, playfield width in pixels.
REQ-002 Parameter FIELD_H, default 480, playfield height in pixels.
REQ-003 Parameter BALL_SZ, default 8, ball edge length in pixels.
REQ-004 Parameter PAD_H, default 64, paddle height in pixels.
REQ-005 Parameter PAD_L_FACE, default 24, x of the left paddle's right face.
REQ-006 Parameter PAD_R_FACE, default 616, x of the right paddle's left face.
REQ-007 clk  in  1  system clock, 50 MHz; the block's only clock.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 clk_ball  in  1  divided ball-speed clock; treated as data, never as a clock.
REQ-010 serve  in  1  single-cycle serve request, clk domain.
REQ-011 paddle_l_y  in  10  top y of the left paddle.
REQ-012 paddle_r_y  in  10  top y of the right paddle.
REQ-013 ball_x  out  10  top-left x of the ball, registered.
REQ-014 ball_y  out  10  top-left y of the ball, registered.
REQ-015 in_play  out  1  high while the FSM is in PLAY.
REQ-016 score_l  out  1  one-cycle pulse: left player scored.
REQ-017 score_r  out  1  one-cycle pulse: right player scored.

Function
REQ-018 clk_ball SHALL pass through a 2-flop synchronizer; its rising edge SHALL produce a one-cycle tick exactly 3 clk cycles after the clk_ball edge.
REQ-019 The FSM SHALL have three states: IDLE (ball centred, waiting), PLAY (moving), SCORE (one cycle).
REQ-020 IDLE->PLAY SHALL occur on serve; the ball SHALL NOT move in the cycle serve is taken, even if tick is coincident.
REQ-021 serve SHALL be ignored in PLAY and SCORE.
REQ-022 In PLAY, ticks SHALL be the only events that update position or direction; each tick moves the ball 1 px in x and 1 px in y along dir_x and dir_y.
REQ-023 Boundary rule: on a tick where a bounce applies to an axis, that axis's direction SHALL flip and its coordinate SHALL stay unchanged.
REQ-024 Y bounce SHALL occur when dir_y is up and ball_y==0, or when dir_y is down and ball_y==FIELD_H-BALL_SZ (472).
REQ-025 Left paddle hit SHALL occur when dir_x is left, ball_x==PAD_L_FACE, and ball_y+BALL_SZ > paddle_l_y and ball_y < paddle_l_y+PAD_H.
REQ-026 Right paddle hit SHALL occur when dir_x is right, ball_x+BALL_SZ==PAD_R_FACE (ball_x==608), and the same overlap test holds against paddle_r_y.
REQ-027 Overlap sums SHALL be computed at 11 bits unsigned, so no wrap-around is possible.
REQ-028 Paddle inputs SHALL be sampled combinationally in the tick cycle and not registered.
REQ-029 A miss SHALL be detected when dir_x is left and ball_x==0 (right player scores), or when dir_x is right and ball_x==FIELD_W-BALL_SZ (632) (left player scores); the FSM SHALL then enter SCORE.
REQ-030 X and Y rules SHALL be evaluated independently in the same tick; a corner hit flips both directions.
REQ-031 In SCORE, the block SHALL pulse score_l or score_r for exactly one cycle, set ball_x=316 and ball_y=236, set dir_x toward the conceding player, set dir_y down, and go to IDLE next cycle.
REQ-032 in_play SHALL equal (state==PLAY); all outputs SHALL be registered.

Reset
REQ-033 On rst the block SHALL set: state IDLE, ball_x=316, ball_y=236, dir_x right, dir_y down, score_l=0, score_r=0, in_play=0, synchronizer and edge flops 0.
REQ-034 rst SHALL take priority over tick, serve and SCORE in the same cycle, and SHALL abort play immediately with no score pulse.

Structure
REQ-035 The state encoding and the field/ball/paddle constants, including the centre values 316 and 236, SHALL live in the shared package pong_pkg.
REQ-036 Synchronizer and edge detection SHALL be one sub-module, tick_sync (clk, rst, async_in -> tick); the FSM and datapath SHALL stay in ball_mover.

Verification
REQ-037 clk_ball rising at cycle N -> tick at N+3; with the ball in PLAY at (316,236), moving right and down, one tick -> (317,237).
REQ-038 Ball at y=0 moving up, one tick -> y stays 0, dir_y down; next tick -> y=1.
REQ-039 Ball at x=24 moving left, ball_y=100, paddle_l_y=40 -> bounce, x stays 24; with paddle_l_y=200 -> no bounce, and the ball keeps moving to x=0.
REQ-040 Ball at x=632 moving right -> SCORE, score_l high for exactly 1 cycle, ball at (316,236), dir_x right, state IDLE, in_play=0.
REQ-041 Serve and tick in the same IDLE cycle -> PLAY with position unchanged; rst asserted mid-PLAY -> reset values on the next cycle with no score pulse.
REQ-042 Corner case: ball at x=608 moving right, y=472 moving down, paddle_r_y=440 -> both directions flip, position unchanged.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared playfield constants, state encoding and geometry helpers for the pong ball logic.
package pong_pkg;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned SUM_W   = 11;

   localparam int unsigned FIELD_W_DEF    = 640;
   localparam int unsigned FIELD_H_DEF    = 480;
   localparam int unsigned BALL_SZ_DEF    = 8;
   localparam int unsigned PAD_H_DEF      = 64;
   localparam int unsigned PAD_L_FACE_DEF = 24;
   localparam int unsigned PAD_R_FACE_DEF = 616;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_SCORE = 2'd2
   } state_e;

   typedef enum logic {
      DX_LEFT  = 1'b0,
      DX_RIGHT = 1'b1
   } dir_x_e;

   typedef enum logic {
      DY_UP   = 1'b0,
      DY_DOWN = 1'b1
   } dir_y_e;

   // Top-left coordinate that centres the ball on one axis.
   function automatic logic [COORD_W-1:0] centre_of(input int unsigned field, input int unsigned ball);
      return COORD_W'((field - ball) / 2);
   endfunction

   localparam logic [COORD_W-1:0] CENTRE_X = centre_of(FIELD_W_DEF, BALL_SZ_DEF);
   localparam logic [COORD_W-1:0] CENTRE_Y = centre_of(FIELD_H_DEF, BALL_SZ_DEF);

   // Vertical overlap of ball and paddle, widened by one bit so the sums cannot wrap.
   function automatic logic pad_overlap(input logic [COORD_W-1:0] ball_y,
                                        input logic [COORD_W-1:0] pad_y,
                                        input int unsigned        ball_sz,
                                        input int unsigned        pad_h);
      logic [SUM_W-1:0] ball_bot;
      logic [SUM_W-1:0] pad_bot;
      ball_bot = SUM_W'(ball_y) + SUM_W'(ball_sz);
      pad_bot  = SUM_W'(pad_y) + SUM_W'(pad_h);
      return (ball_bot > SUM_W'(pad_y)) && (SUM_W'(ball_y) < pad_bot);
   endfunction

endpackage

// File: rtl/tick_sync.sv
// Two-flop synchronizer plus rising-edge detector; emits a registered one-cycle tick.
module tick_sync
(
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic tick
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;
   logic tick_q,  tick_d;

   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      tick_d  = sync2_q & ~prev_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/ball_mover.sv
// Pong ball FSM and position datapath: serve, move on ball ticks, bounce off walls/paddles, score.
module ball_mover
   import pong_pkg::*;
#(
   parameter int unsigned FIELD_W    = FIELD_W_DEF,
   parameter int unsigned FIELD_H    = FIELD_H_DEF,
   parameter int unsigned BALL_SZ    = BALL_SZ_DEF,
   parameter int unsigned PAD_H      = PAD_H_DEF,
   parameter int unsigned PAD_L_FACE = PAD_L_FACE_DEF,
   parameter int unsigned PAD_R_FACE = PAD_R_FACE_DEF
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clk_ball,
   input  logic               serve,
   input  logic [COORD_W-1:0] paddle_l_y,
   input  logic [COORD_W-1:0] paddle_r_y,
   output logic [COORD_W-1:0] ball_x,
   output logic [COORD_W-1:0] ball_y,
   output logic               in_play,
   output logic               score_l,
   output logic               score_r
);

   localparam logic [COORD_W-1:0] CX      = centre_of(FIELD_W, BALL_SZ);
   localparam logic [COORD_W-1:0] CY      = centre_of(FIELD_H, BALL_SZ);
   localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(FIELD_W - BALL_SZ);
   localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(FIELD_H - BALL_SZ);
   localparam logic [COORD_W-1:0] X_PAD_L = COORD_W'(PAD_L_FACE);
   localparam logic [COORD_W-1:0] X_PAD_R = COORD_W'(PAD_R_FACE - BALL_SZ);
   localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);

   state_e             state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   dir_x_e             dir_x_q, dir_x_d;
   dir_y_e             dir_y_q, dir_y_d;
   logic               in_play_q, in_play_d;
   logic               score_l_q, score_l_d;
   logic               score_r_q, score_r_d;

   logic tick;
   logic hit_l, hit_r, lost_l, lost_r, bounce_y;

   tick_sync u_tick_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (clk_ball),
      .tick     (tick)
   );

   // Collision terms use the paddle inputs directly in the tick cycle.
   always_comb begin
      hit_l    = (dir_x_q == DX_LEFT) && (x_q == X_PAD_L) &&
                 pad_overlap(y_q, paddle_l_y, BALL_SZ, PAD_H);
      hit_r    = (dir_x_q == DX_RIGHT) && (x_q == X_PAD_R) &&
                 pad_overlap(y_q, paddle_r_y, BALL_SZ, PAD_H);
      lost_l   = (dir_x_q == DX_LEFT)  && (x_q == '0);
      lost_r   = (dir_x_q == DX_RIGHT) && (x_q == X_MAX);
      bounce_y = ((dir_y_q == DY_UP)   && (y_q == '0)) ||
                 ((dir_y_q == DY_DOWN) && (y_q == Y_MAX));
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      dir_x_d   = dir_x_q;
      dir_y_d   = dir_y_q;
      score_l_d = 1'b0;
      score_r_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (serve) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (tick) begin
               if (lost_l || lost_r) begin
                  state_d = ST_SCORE;
               end else begin
                  if (hit_l || hit_r)
                     dir_x_d = (dir_x_q == DX_LEFT) ? DX_RIGHT : DX_LEFT;
                  else if (dir_x_q == DX_RIGHT)
                     x_d = x_q + ONE;
                  else
                     x_d = x_q - ONE;

                  if (bounce_y)
                     dir_y_d = (dir_y_q == DY_UP) ? DY_DOWN : DY_UP;
                  else if (dir_y_q == DY_DOWN)
                     y_d = y_q + ONE;
                  else
                     y_d = y_q - ONE;
               end
            end
         end
         ST_SCORE: begin
            // dir_x still points at the wall the ball left through, i.e. at the conceding side.
            state_d = ST_IDLE;
            x_d     = CX;
            y_d     = CY;
            dir_y_d = DY_DOWN;
            if (dir_x_q == DX_RIGHT) score_l_d = 1'b1;
            else                     score_r_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      in_play_d = (state_d == ST_PLAY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         x_q       <= CX;
         y_q       <= CY;
         dir_x_q   <= DX_RIGHT;
         dir_y_q   <= DY_DOWN;
         in_play_q <= 1'b0;
         score_l_q <= 1'b0;
         score_r_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dir_x_q   <= dir_x_d;
         dir_y_q   <= dir_y_d;
         in_play_q <= in_play_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
      end
   end

   assign ball_x  = x_q;
   assign ball_y  = y_q;
   assign in_play = in_play_q;
   assign score_l = score_l_q;
   assign score_r = score_r_q;

endmodule
